// File: rtl/mips_bus_pkg.sv
// Shared types for the SRAM-like bus arbiter: arbiter state, transaction owner, access size codes.
package mips_bus_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like master port between fetch and data sides, one transaction outstanding.
// Latency: grant -> *_data_ok min 2 cycles; requesters are held off (addr_ok low) while busy.
module sram_bus_arbiter
  import mips_bus_pkg::*;
(
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_discard,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  arb_state_t state, state_nxt;
  owner_t     owner, last_owner;
  logic       discard, discard_nxt;
  logic       inst_win, data_win, done;

  // Round-robin: on a tie the side that did not own the last grant wins.
  assign inst_win = inst_req & (~data_req | (last_owner == OWN_DATA));
  assign data_win = data_req & (~inst_req | (last_owner == OWN_INST));
  assign done     = (state == ARB_DATA) & m_data_ok;

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    case (state)
      ARB_IDLE: begin
        if (inst_win | data_win) begin
          state_nxt   = ARB_ADDR;
          discard_nxt = inst_win & inst_discard;
        end
      end
      ARB_ADDR: begin
        if (m_addr_ok) state_nxt = ARB_DATA;
        if ((owner == OWN_INST) && inst_discard) discard_nxt = 1'b1;
      end
      ARB_DATA: begin
        if (m_data_ok) begin
          state_nxt   = ARB_IDLE;
          discard_nxt = 1'b0;
        end else if ((owner == OWN_INST) && inst_discard) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state      <= ARB_IDLE;
      discard    <= 1'b0;
      owner      <= OWN_INST;
      last_owner <= OWN_INST;
      m_wr       <= 1'b0;
      m_size     <= 2'd0;
      m_addr     <= 32'd0;
      m_wdata    <= 32'd0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
      if ((state == ARB_IDLE) && (inst_win | data_win)) begin
        owner      <= data_win ? OWN_DATA : OWN_INST;
        last_owner <= data_win ? OWN_DATA : OWN_INST;
        m_wr       <= data_win ? data_wr : 1'b0;
        m_size     <= data_win ? data_size : SIZE_W;
        m_addr     <= data_win ? data_addr : inst_addr;
        m_wdata    <= data_win ? data_wdata : 32'd0;
      end
    end
  end

  // addr_ok is masked during reset so a held request is never acknowledged then.
  assign inst_addr_ok = Clr_n & (state == ARB_IDLE) & inst_win;
  assign data_addr_ok = Clr_n & (state == ARB_IDLE) & data_win;
  assign inst_data_ok = done & (owner == OWN_INST) & ~discard & ~inst_discard;
  assign data_data_ok = done & (owner == OWN_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign m_req        = (state == ARB_ADDR);

endmodule
